// File: rtl/gcn_layer_controller.sv
// Phase sequencer for one GCN inference pass: weight-column transform, row-wise
// aggregation, then an argmax sweep, bracketed by a start/done handshake.
module gcn_layer_controller #(
    parameter int unsigned FEATURE_ROWS          = 6,
    parameter int unsigned WEIGHT_COLS           = 3,
    parameter int unsigned COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int unsigned COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             trans_done,
    input  logic                             argmax_done,
    output logic                             enable_trans,
    output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_col_addr,
    output logic                             enable_agg,
    output logic [COUNTER_FEATURE_WIDTH-1:0] agg_row,
    output logic                             done_comb,
    output logic                             busy,
    output logic                             done
);

    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_MAX = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_MAX = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRANS    = 3'd1,
        S_AGG      = 3'd2,
        S_ARGMAX   = 3'd3,
        S_WAIT_ARG = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    state_e                            state_q, state_d;
    logic [COUNTER_WEIGHT_WIDTH-1:0]   col_cnt_q, col_cnt_d;
    logic [COUNTER_FEATURE_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [COUNTER_FEATURE_WIDTH-1:0]  arg_cnt_q, arg_cnt_d;

    logic                              enable_trans_q, enable_trans_d;
    logic [COUNTER_WEIGHT_WIDTH-1:0]   weight_col_addr_q, weight_col_addr_d;
    logic                              enable_agg_q, enable_agg_d;
    logic [COUNTER_FEATURE_WIDTH-1:0]  agg_row_q, agg_row_d;
    logic                              done_comb_q, done_comb_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            col_cnt_q         <= '0;
            row_cnt_q         <= '0;
            arg_cnt_q         <= '0;
            enable_trans_q    <= 1'b0;
            weight_col_addr_q <= '0;
            enable_agg_q      <= 1'b0;
            agg_row_q         <= '0;
            done_comb_q       <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            col_cnt_q         <= col_cnt_d;
            row_cnt_q         <= row_cnt_d;
            arg_cnt_q         <= arg_cnt_d;
            enable_trans_q    <= enable_trans_d;
            weight_col_addr_q <= weight_col_addr_d;
            enable_agg_q      <= enable_agg_d;
            agg_row_q         <= agg_row_d;
            done_comb_q       <= done_comb_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
        end
    end

    // Next state and phase counters; each counter clears on leaving its phase
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        arg_cnt_d = arg_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_TRANS;
                    col_cnt_d = '0;
                end
            end
            S_TRANS: begin
                if (trans_done) begin
                    if (col_cnt_q == COL_MAX) begin
                        state_d   = S_AGG;
                        col_cnt_d = '0;
                        row_cnt_d = '0;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            S_AGG: begin
                if (row_cnt_q == ROW_MAX) begin
                    state_d   = S_ARGMAX;
                    row_cnt_d = '0;
                    arg_cnt_d = '0;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            S_ARGMAX: begin
                if (arg_cnt_q == ROW_MAX) begin
                    state_d   = S_WAIT_ARG;
                    arg_cnt_d = '0;
                end else begin
                    arg_cnt_d = arg_cnt_q + 1'b1;
                end
            end
            S_WAIT_ARG: begin
                if (argmax_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                col_cnt_d = '0;
                row_cnt_d = '0;
                arg_cnt_d = '0;
            end
        endcase
    end

    // Moore decode of the upcoming state, registered so outputs come straight from flops
    always_comb begin
        enable_trans_d    = 1'b0;
        weight_col_addr_d = '0;
        enable_agg_d      = 1'b0;
        agg_row_d         = '0;
        done_comb_d       = 1'b0;
        busy_d            = (state_d != S_IDLE);
        done_d            = 1'b0;
        unique case (state_d)
            S_TRANS: begin
                enable_trans_d    = 1'b1;
                weight_col_addr_d = col_cnt_d;
            end
            S_AGG: begin
                enable_agg_d = 1'b1;
                agg_row_d    = row_cnt_d;
            end
            S_ARGMAX: done_comb_d = 1'b1;
            S_DONE:   done_d      = 1'b1;
            default: begin
                enable_trans_d = 1'b0;
            end
        endcase
    end

    assign enable_trans    = enable_trans_q;
    assign weight_col_addr = weight_col_addr_q;
    assign enable_agg      = enable_agg_q;
    assign agg_row         = agg_row_q;
    assign done_comb       = done_comb_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_gcn_layer_controller.sv
// Bench for gcn_layer_controller: timeline model compared every cycle, plus
// directed passes with literal expectations and a stand-in argmax row sweep.
module tb_gcn_layer_controller;

    localparam int FR = 6;
    localparam int WC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       trans_done = 1'b0;
    logic       argmax_done = 1'b0;
    logic       enable_trans;
    logic [1:0] weight_col_addr;
    logic       enable_agg;
    logic [2:0] agg_row;
    logic       done_comb;
    logic       busy;
    logic       done;

    gcn_layer_controller #(
        .FEATURE_ROWS(FR),
        .WEIGHT_COLS (WC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .trans_done     (trans_done),
        .argmax_done    (argmax_done),
        .enable_trans   (enable_trans),
        .weight_col_addr(weight_col_addr),
        .enable_agg     (enable_agg),
        .agg_row        (agg_row),
        .done_comb      (done_comb),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done_pulses = 0;
    int n_comb_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Timeline model: a pass is "columns transformed so far", then a count of
    // cycles since the final column finished; outputs follow from those numbers.
    bit m_active   = 1'b0;
    int m_cols     = 0;
    int m_t        = 0;
    bit m_done_now = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_cols = 0; m_t = 0; m_done_now = 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_cols = 0; m_t = 0;
            end
        end else if (m_done_now) begin
            m_active = 1'b0; m_done_now = 1'b0; m_cols = 0; m_t = 0;
        end else if (m_cols < WC) begin
            if (trans_done) begin
                m_cols++;
                if (m_cols == WC) m_t = 1;
            end
        end else if (m_t <= 2 * FR) begin
            m_t++;
        end else if (argmax_done) begin
            m_done_now = 1'b1;
        end
    end

    bit cmp_en = 1'b1;

    always @(negedge clk) begin
        if (cmp_en) begin
            bit e_trans, e_agg, e_comb;
            int e_addr, e_row;
            e_trans = m_active && !m_done_now && (m_cols < WC);
            e_agg   = m_active && !m_done_now && (m_cols == WC) && (m_t >= 1) && (m_t <= FR);
            e_comb  = m_active && !m_done_now && (m_cols == WC) && (m_t > FR) && (m_t <= 2 * FR);
            e_addr  = e_trans ? m_cols : 0;
            e_row   = e_agg ? m_t - 1 : 0;
            check("m_enable_trans", enable_trans, e_trans);
            check("m_weight_col_addr", weight_col_addr, e_addr);
            check("m_enable_agg", enable_agg, e_agg);
            check("m_agg_row", agg_row, e_row);
            check("m_done_comb", done_comb, e_comb);
            check("m_busy", busy, m_active);
            check("m_done", done, m_done_now);
            check("m_onehot_enables", 32'(enable_trans) + 32'(enable_agg) + 32'(done_comb) <= 1, 1);
            if (done === 1'b1) n_done_pulses++;
            if (done_comb === 1'b1) n_comb_cycles++;
        end
    end

    // Stand-in for the argmax block: one matrix row scored per done_comb cycle
    int mat [FR][WC] = '{'{1, 2, 9}, '{8, 3, 4}, '{0, 7, 5}, '{2, 6, 1}, '{9, 4, 3}, '{5, 1, 8}};
    int answers [FR];
    int ptr = 0;

    function automatic int row_argmax(input int r);
        int best = 0;
        for (int c = 1; c < WC; c++) if (mat[r][c] > mat[r][best]) best = c;
        return best;
    endfunction

    task automatic start_pass();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic trans_every4();
        for (int c = 0; c < WC; c++) begin
            check("trans_addr", weight_col_addr, c);
            check("trans_en", enable_trans, 1);
            tick(3);
            check("trans_addr_hold", weight_col_addr, c);
            trans_done = 1'b1;
            tick(1);
            trans_done = 1'b0;
        end
    endtask

    // Entered on the first AGG cycle; ends on the first IDLE cycle after done
    task automatic post_phase(input int delay, input bit strays);
        for (int i = 0; i < FR; i++) begin
            check("agg_row", agg_row, i);
            check("agg_en", enable_agg, 1);
            start       = strays && (i == 2);
            argmax_done = strays && (i == 2);
            tick(1);
        end
        start = 1'b0;
        argmax_done = 1'b0;
        for (int i = 0; i < FR; i++) begin
            check("done_comb", done_comb, 1);
            answers[ptr] = row_argmax(ptr);
            ptr = (ptr + 1) % FR;
            trans_done = strays && (i == 1);
            tick(1);
        end
        trans_done = 1'b0;
        for (int d = 0; d < delay; d++) begin
            check("wait_done_comb", done_comb, 0);
            check("wait_busy", busy, 1);
            check("wait_done", done, 0);
            trans_done = strays;
            start      = strays;
            tick(1);
        end
        trans_done = 1'b0;
        start = 1'b0;
        check("wait_first_comb", done_comb, 0);
        argmax_done = 1'b1;
        tick(1);
        argmax_done = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        start = strays;
        tick(1);
        start = 1'b0;
        check("done_after", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int exp_ans [FR];
        exp_ans = '{2, 0, 1, 1, 0, 2};
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_trans", enable_trans, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick(2);
        check("idle_busy", busy, 0);

        // Test 1: nominal pass
        start_pass();
        trans_every4();
        post_phase(0, 1'b0);

        // Test 2: trans_done tied high for the whole transform phase
        tick(1);
        start = 1'b1;
        trans_done = 1'b1;
        tick(1);
        start = 1'b0;
        for (int c = 0; c < WC; c++) begin
            check("tied_addr", weight_col_addr, c);
            tick(1);
        end
        trans_done = 1'b0;
        post_phase(0, 1'b0);

        // Test 3: start pulses mid-pass are ignored; a fresh start runs a full pass
        start = 1'b1;
        tick(2);
        start = 1'b0;
        trans_every4();
        post_phase(0, 1'b1);
        tick(2);
        check("no_retrigger", busy, 0);
        start_pass();
        trans_every4();
        post_phase(0, 1'b0);

        // Test 4: reset during aggregation row 3
        start_pass();
        trans_done = 1'b1;
        tick(3);
        trans_done = 1'b0;
        tick(3);
        check("pre_reset_row", agg_row, 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_agg", enable_agg, 0);
        check("abort_row", agg_row, 0);
        check("abort_comb", done_comb, 0);
        check("abort_trans", enable_trans, 0);
        check("abort_done", done, 0);
        tick(1);
        start_pass();
        check("restart_addr", weight_col_addr, 0);
        trans_every4();
        post_phase(0, 1'b0);

        // Test 5: argmax_done withheld, with stray pulses everywhere
        argmax_done = 1'b1;
        start_pass();
        argmax_done = 1'b0;
        trans_every4();
        post_phase(5, 1'b1);

        // Test 6: two passes through the argmax stand-in give identical answers
        ptr = 0;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < FR; r++) answers[r] = -1;
            start_pass();
            trans_every4();
            post_phase(0, 1'b0);
            for (int r = 0; r < FR; r++) check("argmax_answer", answers[r], exp_ans[r]);
            check("ptr_realigned", ptr, 0);
        end

        tick(2);
        check("done_pulse_count", n_done_pulses, 8);
        check("done_comb_cycles", n_comb_cycles, 8 * FR);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
